// File: rtl/pid_pkg.sv
// Shared helpers for the parametrised PID steering controller:
// saturating clip, default gains and the wheel-speed pair type.
package pid_pkg;

  localparam int DEF_P_COEFF = 5;
  localparam int DEF_D_COEFF = 6;

  // Left/right speeds carried at 32 bits; callers slice to their output width.
  typedef struct packed {
    logic signed [31:0] lft;
    logic signed [31:0] rght;
  } spd_pair_t;

  // Clip a signed value into the range of a w-bit two's complement number.
  function automatic logic signed [31:0] clip_s(input logic signed [31:0] v, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (v > hi)
      return hi;
    else if (v < lo)
      return lo;
    else
      return v;
  endfunction

  // Differential drive: forward command plus/minus the steering correction, clipped.
  function automatic spd_pair_t mix_speeds(input logic signed [31:0] fwd,
                                           input logic signed [31:0] pid,
                                           input int w);
    spd_pair_t r;
    r.lft  = clip_s(fwd + pid, w);
    r.rght = clip_s(fwd - pid, w);
    return r;
  endfunction

endpackage

// File: rtl/pid_deriv_hist.sv
// Derivative history: D_DEPTH-deep shift register of accepted error samples
// and the clipped difference between the current sample and the oldest entry.
module pid_deriv_hist
  import pid_pkg::*;
#(
  parameter int SAT_W    = 10,
  parameter int D_DEPTH  = 2,
  parameter int D_DIFF_W = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       shift,
  input  logic signed [SAT_W-1:0]    sample,
  output logic signed [D_DIFF_W-1:0] diff
);

  logic signed [SAT_W-1:0] hist [D_DEPTH];
  logic signed [31:0]      diff_full;
  logic signed [31:0]      diff_clip;

  // Shift in a new sample only on accepted samples; clear when the robot stops.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < D_DEPTH; i++) hist[i] <= '0;
    end else if (shift) begin
      hist[0] <= sample;
      for (int i = 1; i < D_DEPTH; i++) hist[i] <= hist[i-1];
    end
  end

  // Difference uses the history as it stands before this cycle's shift.
  assign diff_full = 32'(sample) - 32'(hist[D_DEPTH-1]);
  assign diff_clip = clip_s(diff_full, D_DIFF_W);
  assign diff      = diff_clip[D_DIFF_W-1:0];

endmodule

// File: rtl/pid_ctrl_param.sv
// Parametrised PID steering controller: clips the heading error, runs a
// P + I + D correction and mixes it with the forward command into clipped
// left/right wheel speeds, two clocks after each accepted error sample.
module pid_ctrl_param
  import pid_pkg::*;
#(
  parameter int ERR_W    = 12,
  parameter int SAT_W    = 10,
  parameter int FRWRD_W  = 10,
  parameter int SPD_W    = 11,
  parameter int INTG_W   = 16,
  parameter int I_SHIFT  = 4,
  parameter int P_COEFF  = DEF_P_COEFF,
  parameter int D_COEFF  = DEF_D_COEFF,
  parameter int D_DIFF_W = 7,
  parameter int D_DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    moving,
  input  logic                    err_vld,
  input  logic signed [ERR_W-1:0] error,
  input  logic [FRWRD_W-1:0]      frwrd,
  output logic signed [SPD_W-1:0] lft_spd,
  output logic signed [SPD_W-1:0] rght_spd,
  output logic                    out_vld
);

  // Stage 1 registers
  logic signed [SAT_W-1:0]    err_s1;
  logic                       vld_s1;
  logic                       mov_s1;
  logic [FRWRD_W-1:0]         frwrd_s1;

  // Controller state
  logic signed [INTG_W-1:0]   intg;

  // Combinational datapath
  logic signed [31:0]         err_clip;
  logic signed [INTG_W-1:0]   err_ext;
  logic signed [INTG_W-1:0]   intg_sum;
  logic                       intg_ovf;
  logic signed [INTG_W-1:0]   intg_upd;
  logic signed [D_DIFF_W-1:0] d_diff;
  logic signed [31:0]         p_term;
  logic signed [31:0]         i_term;
  logic signed [31:0]         d_term;
  logic signed [31:0]         pid_sum;
  logic signed [31:0]         fwd_ext;
  spd_pair_t                  spd;
  logic                       accept;

  assign err_clip = clip_s(32'(error), SAT_W);
  assign accept   = vld_s1 && mov_s1;

  // Stage 1: capture the clipped error and the qualifying controls.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_s1   <= '0;
      vld_s1   <= 1'b0;
      mov_s1   <= 1'b0;
      frwrd_s1 <= '0;
    end else begin
      err_s1   <= err_clip[SAT_W-1:0];
      vld_s1   <= err_vld;
      mov_s1   <= moving;
      frwrd_s1 <= frwrd;
    end
  end

  pid_deriv_hist #(
    .SAT_W    (SAT_W),
    .D_DEPTH  (D_DEPTH),
    .D_DIFF_W (D_DIFF_W)
  ) u_deriv (
    .clk    (clk),
    .rst    (rst),
    .clr    (!mov_s1),
    .shift  (accept),
    .sample (err_s1),
    .diff   (d_diff)
  );

  // Integrator holds instead of wrapping when the addition overflows.
  assign err_ext  = INTG_W'(err_s1);
  assign intg_sum = intg + err_ext;
  assign intg_ovf = (intg[INTG_W-1] == err_ext[INTG_W-1]) &&
                    (intg_sum[INTG_W-1] != intg[INTG_W-1]);
  assign intg_upd = intg_ovf ? intg : intg_sum;

  // The I term sees the integrator value that includes the current sample.
  assign p_term  = 32'(err_s1) * P_COEFF;
  assign i_term  = 32'(intg_upd) >>> I_SHIFT;
  assign d_term  = 32'(d_diff) * D_COEFF;
  assign pid_sum = p_term + i_term + d_term;
  assign fwd_ext = 32'(signed'({1'b0, frwrd_s1}));
  assign spd     = mix_speeds(fwd_ext, pid_sum, SPD_W);

  // Stage 2: update state and outputs on accepted samples; stopping clears all.
  always_ff @(posedge clk) begin
    if (rst) begin
      intg     <= '0;
      lft_spd  <= '0;
      rght_spd <= '0;
      out_vld  <= 1'b0;
    end else if (!mov_s1) begin
      intg     <= '0;
      lft_spd  <= '0;
      rght_spd <= '0;
      out_vld  <= 1'b0;
    end else if (vld_s1) begin
      intg     <= intg_upd;
      lft_spd  <= spd.lft[SPD_W-1:0];
      rght_spd <= spd.rght[SPD_W-1:0];
      out_vld  <= 1'b1;
    end else begin
      out_vld  <= 1'b0;
    end
  end

endmodule
